draw_rect_ctl: RTL and testbench
================================

DRAW_RECT_CTL -- requirements
Module: draw_rect_ctl

Interface
REQ-001 Parameter RECT_WIDTH, 48, rectangle width in pixels; SHALL be 1..1023.
REQ-002 Parameter RECT_HEIGHT, 64, rectangle height in lines; SHALL be 1..1023.
REQ-003 Parameter RECT_COLOR, 12'hb9b, fill/outline colour.
REQ-004 Parameter BORDER, 2, outline thickness in pixels; SHALL be at least 1 and no more than half of the smaller of RECT_WIDTH and RECT_HEIGHT.
REQ-005 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 bus_in  vga_bus  -  incoming timing and rgb: hcount/vcount 11b, hsync/vsync/hblnk/vblnk 1b, rgb 12b.
REQ-008 bus_out  vga_bus  -  outgoing timing and rgb, same fields as bus_in.
REQ-009 xpos  input  12  requested left edge.
REQ-010 ypos  input  12  requested top edge.
REQ-011 pos_valid  input  1  xpos/ypos/outline_en are valid this cycle.
REQ-012 outline_en  input  1  1 = draw a BORDER-thick outline only; 0 = draw a filled rectangle.
REQ-013 pos_ack  output  1  one-cycle pulse when a request becomes active.

Function
REQ-014 Every cycle with pos_valid=1 SHALL capture xpos, ypos and outline_en into pending registers and set pend_flag; the latest request SHALL win.
REQ-015 A frame boundary SHALL be the cycle where bus_in.vblnk=1 and its registered previous value is 0.
REQ-016 At a boundary with pend_flag=1, the pending values SHALL load into the active registers; pend_flag SHALL clear, act_valid SHALL set, and pos_ack SHALL be 1 on the following cycle only.
REQ-017 If pos_valid=1 on a boundary cycle, the incoming values SHALL load directly into the active registers, overriding pending; pend_flag SHALL clear and pos_ack SHALL pulse as in REQ-016.
REQ-018 Active geometry SHALL change only at boundaries, so no frame ever shows a torn rectangle.
REQ-019 A hit SHALL require all of the following: hblnk=0, vblnk=0, act_valid=1, x<=hcount<x+RECT_WIDTH and y<=vcount<y+RECT_HEIGHT.
REQ-020 All sums in the hit test SHALL be evaluated at 13 bits; edges beyond the counter range SHALL clip, with no wrap-around.
REQ-021 In outline mode, pixels with x+BORDER<=hcount<x+RECT_WIDTH-BORDER and y+BORDER<=vcount<y+RECT_HEIGHT-BORDER SHALL be excluded from the hit.
REQ-022 Stage 1 SHALL register the hit flag, bus_in.rgb and all timing fields.
REQ-023 Stage 2 SHALL register rgb as RECT_COLOR on a hit and as the delayed input rgb otherwise, plus the delayed timing fields.
REQ-024 Latency SHALL be exactly 2 cycles for every bus field, with all fields aligned.
REQ-025 Before the first committed position, bus_out SHALL equal bus_in delayed by 2 cycles.

Reset
REQ-026 While rst=0, all bus_out fields, pos_ack, pend_flag, act_valid, the pending/active registers and the previous-vblnk register SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL discard both pending and active positions.
REQ-028 After release, no rectangle SHALL be drawn until REQ-016 or REQ-017 commits a new position.

Structure
REQ-029 Defaults for RECT_COLOR, the pipeline latency constant (2) and the coordinate width (12) SHALL live in vga_pkg.
REQ-030 The timing-field delay SHALL be a sub-module, vga_delay, parametrised by depth and instantiated with depth 2.

Verification
REQ-031 Reset, then pos_valid with x=50, y=50, fill; run 2 frames -> pixels (50..97, 50..113) = hb9b, (98,50) = input rgb, pos_ack pulses once at the first vblnk rise plus 1 cycle.
REQ-032 Outline mode with x=100, y=100 -> (100,100) and (101,130) = hb9b, (102,102) = input rgb, (147,163) = hb9b.
REQ-033 Mid-frame pos_valid x=200 while the active position is 50 -> the current frame still draws at 50, the next frame draws at 200.
REQ-034 Three pos_valid pulses (x=10, 20, 30) in one frame -> only x=30 is committed, with a single pos_ack.
REQ-035 pos_valid on the exact boundary cycle with x=300 -> active x=300 that frame, pos_ack one cycle later.
REQ-036 Set x=1000 with 800-pixel active width, then assert reset mid-frame -> the clipped region is drawn with no wrap at hcount 0..7; after reset the output equals the input delayed by 2 cycles until a new commit.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA bus types and default constants for the rectangle overlay.
package vga_pkg;

    localparam int COORD_W = 12;
    localparam int PIPE_LAT = 2;
    localparam logic [11:0] RECT_COLOR_DEF = 12'hb9b;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
    } vga_tim_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus_t;

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth register chain used to keep timing fields aligned with rgb.
module vga_delay #(
    parameter int W     = 26,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe_q [DEPTH];
    logic [W-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle overlay on a VGA stream; geometry updates only at frame start.
module draw_rect_ctl
    import vga_pkg::*;
#(
    parameter int          RECT_WIDTH  = 48,
    parameter int          RECT_HEIGHT = 64,
    parameter logic [11:0] RECT_COLOR  = RECT_COLOR_DEF,
    parameter int          BORDER      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  vga_bus_t           bus_in,
    output vga_bus_t           bus_out,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic               pos_valid,
    input  logic               outline_en,
    output logic               pos_ack
);

    logic               vblnk_prev_q, vblnk_prev_d;
    logic [COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic               pend_outl_q, pend_outl_d, pend_flag_q, pend_flag_d;
    logic [COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic               act_outl_q, act_outl_d, act_valid_q, act_valid_d;
    logic               ack_q, ack_d, hit_q, hit_d;
    logic [11:0]        rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic               boundary;

    // 13-bit sums so edges past the counter range clip instead of wrapping
    logic [12:0] hc, vc, x0, x1, y0, y1, xi0, xi1, yi0, yi1;
    logic        in_rect, in_inner;

    assign boundary = bus_in.vblnk & ~vblnk_prev_q;
    assign hc  = {2'b00, bus_in.hcount};
    assign vc  = {2'b00, bus_in.vcount};
    assign x0  = {1'b0, act_x_q};
    assign y0  = {1'b0, act_y_q};
    assign x1  = x0 + 13'(RECT_WIDTH);
    assign y1  = y0 + 13'(RECT_HEIGHT);
    assign xi0 = x0 + 13'(BORDER);
    assign yi0 = y0 + 13'(BORDER);
    assign xi1 = x1 - 13'(BORDER);
    assign yi1 = y1 - 13'(BORDER);

    assign in_rect  = (hc >= x0) && (hc < x1) && (vc >= y0) && (vc < y1);
    assign in_inner = (hc >= xi0) && (hc < xi1) && (vc >= yi0) && (vc < yi1);

    always_comb begin
        vblnk_prev_d = bus_in.vblnk;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_outl_d  = pend_outl_q;
        pend_flag_d  = pend_flag_q;
        act_x_d      = act_x_q;
        act_y_d      = act_y_q;
        act_outl_d   = act_outl_q;
        act_valid_d  = act_valid_q;
        ack_d        = 1'b0;
        if (pos_valid) begin
            pend_x_d    = xpos;
            pend_y_d    = ypos;
            pend_outl_d = outline_en;
            pend_flag_d = 1'b1;
        end
        if (boundary && (pos_valid || pend_flag_q)) begin
            act_x_d     = pos_valid ? xpos : pend_x_q;
            act_y_d     = pos_valid ? ypos : pend_y_q;
            act_outl_d  = pos_valid ? outline_en : pend_outl_q;
            act_valid_d = 1'b1;
            pend_flag_d = 1'b0;
            ack_d       = 1'b1;
        end
        hit_d  = ~bus_in.hblnk & ~bus_in.vblnk & act_valid_q & in_rect
               & ~(act_outl_q & in_inner);
        rgb1_d = bus_in.rgb;
        rgb2_d = hit_q ? RECT_COLOR : rgb1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_prev_q <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_outl_q  <= 1'b0;
            pend_flag_q  <= 1'b0;
            act_x_q      <= '0;
            act_y_q      <= '0;
            act_outl_q   <= 1'b0;
            act_valid_q  <= 1'b0;
            ack_q        <= 1'b0;
            hit_q        <= 1'b0;
            rgb1_q       <= '0;
            rgb2_q       <= '0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_outl_q  <= pend_outl_d;
            pend_flag_q  <= pend_flag_d;
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            act_outl_q   <= act_outl_d;
            act_valid_q  <= act_valid_d;
            ack_q        <= ack_d;
            hit_q        <= hit_d;
            rgb1_q       <= rgb1_d;
            rgb2_q       <= rgb2_d;
        end
    end

    vga_tim_t tim_in, tim_out;

    always_comb begin
        tim_in.hcount = bus_in.hcount;
        tim_in.hsync  = bus_in.hsync;
        tim_in.hblnk  = bus_in.hblnk;
        tim_in.vcount = bus_in.vcount;
        tim_in.vsync  = bus_in.vsync;
        tim_in.vblnk  = bus_in.vblnk;
    end

    vga_delay #(
        .W     ($bits(vga_tim_t)),
        .DEPTH (PIPE_LAT)
    ) u_tim_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (tim_in),
        .dout (tim_out)
    );

    always_comb begin
        bus_out.hcount = tim_out.hcount;
        bus_out.hsync  = tim_out.hsync;
        bus_out.hblnk  = tim_out.hblnk;
        bus_out.vcount = tim_out.vcount;
        bus_out.vsync  = tim_out.vsync;
        bus_out.vblnk  = tim_out.vblnk;
        bus_out.rgb    = rgb2_q;
    end

    assign pos_ack = ack_q;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Randomized and directed bench for draw_rect_ctl against a pixel-level model.
module tb_draw_rect_ctl;
    import vga_pkg::*;

    localparam int          W   = 48;
    localparam int          H   = 64;
    localparam int          B   = 2;
    localparam logic [11:0] COL = 12'hb9b;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    vga_bus_t    bus_in, bus_out;
    logic [11:0] xpos, ypos;
    logic        pos_valid, outline_en, pos_ack;

    always #5 clk = ~clk;

    draw_rect_ctl #(
        .RECT_WIDTH  (W),
        .RECT_HEIGHT (H),
        .RECT_COLOR  (COL),
        .BORDER      (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .xpos       (xpos),
        .ypos       (ypos),
        .pos_valid  (pos_valid),
        .outline_en (outline_en),
        .pos_ack    (pos_ack)
    );

    int n_chk = 0;
    int n_pass = 0;
    int ack_cnt = 0;

    int m_px, m_py, m_ax, m_ay;
    bit m_po, m_pf, m_ao, m_av, m_prev, m_ack;
    vga_bus_t expq[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic vga_bus_t ref_pix(vga_bus_t b);
        vga_bus_t r;
        int hc, vc;
        bit inr, inn;
        r  = b;
        hc = int'(b.hcount);
        vc = int'(b.vcount);
        inr = hc >= m_ax && hc < m_ax + W && vc >= m_ay && vc < m_ay + H;
        inn = hc >= m_ax + B && hc < m_ax + W - B
           && vc >= m_ay + B && vc < m_ay + H - B;
        if (m_av && !b.hblnk && !b.vblnk && inr && !(m_ao && inn))
            r.rgb = COL;
        return r;
    endfunction

    task automatic model_reset;
        m_px = 0; m_py = 0; m_ax = 0; m_ay = 0;
        m_po = 0; m_pf = 0; m_ao = 0; m_av = 0;
        m_prev = 0; m_ack = 0;
        expq = {};
        expq.push_back(vga_bus_t'(0));
    endtask

    task automatic tick;
        vga_bus_t e;
        bit bnd;
        expq.push_back(ref_pix(bus_in));
        bnd = bus_in.vblnk && !m_prev;
        m_prev = bus_in.vblnk;
        m_ack = 0;
        if (bnd && pos_valid) begin
            m_ax = int'(xpos); m_ay = int'(ypos); m_ao = outline_en;
            m_av = 1; m_pf = 0; m_ack = 1;
        end else if (bnd && m_pf) begin
            m_ax = m_px; m_ay = m_py; m_ao = m_po;
            m_av = 1; m_pf = 0; m_ack = 1;
        end else if (pos_valid) begin
            m_px = int'(xpos); m_py = int'(ypos); m_po = outline_en;
            m_pf = 1;
        end
        @(posedge clk);
        #1;
        e = expq.pop_front();
        check("bus", 64'(bus_out), 64'(e));
        check("ack", 64'(pos_ack), 64'(m_ack));
        if (pos_ack) ack_cnt++;
    endtask

    task automatic drive(int hc, int vc, bit vb, logic [11:0] rgb);
        bus_in.hcount = 11'(hc);
        bus_in.hblnk  = (hc >= 800);
        bus_in.hsync  = (hc >= 840 && hc < 968);
        bus_in.vcount = 11'(vc);
        bus_in.vblnk  = vb;
        bus_in.vsync  = vb & vc[0];
        bus_in.rgb    = rgb;
    endtask

    task automatic idle;
        drive($urandom_range(0, 799), $urandom_range(0, 599), 1'b0,
              12'($urandom));
        tick();
    endtask

    task automatic vb_pulse(int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 1055), 600 + i, 1'b1, 12'($urandom));
            tick();
        end
    endtask

    task automatic req(int x, int y, bit ol);
        pos_valid  = 1'b1;
        xpos       = 12'(x);
        ypos       = 12'(y);
        outline_en = ol;
        idle();
        pos_valid  = 1'b0;
    endtask

    task automatic probe(string tag, int hc, int vc, bit exp_hit);
        drive(hc, vc, 1'b0, 12'h123);
        tick();
        idle();
        check(tag, 64'(bus_out.rgb), exp_hit ? 64'(COL) : 64'h123);
    endtask

    initial begin
        pos_valid = 0; outline_en = 0; xpos = 0; ypos = 0;
        drive(10, 10, 1'b0, 12'hfff);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus", 64'(bus_out), 64'h0);
        check("rst_ack", 64'(pos_ack), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // filled rectangle at (50,50), two frames, single ack
        idle();
        probe("pre_commit", 50, 50, 1'b0);
        ack_cnt = 0;
        req(50, 50, 1'b0);
        vb_pulse(4);
        probe("fill_tl", 50, 50, 1'b1);
        probe("fill_br", 97, 113, 1'b1);
        probe("fill_right", 98, 50, 1'b0);
        probe("fill_below", 50, 114, 1'b0);
        probe("fill_left", 49, 60, 1'b0);
        vb_pulse(4);
        probe("fill_f2", 97, 50, 1'b1);
        check("ack_once", 64'(ack_cnt), 64'd1);

        // outline
        req(100, 100, 1'b1);
        vb_pulse(3);
        probe("ol_corner", 100, 100, 1'b1);
        probe("ol_left", 101, 130, 1'b1);
        probe("ol_inner", 102, 102, 1'b0);
        probe("ol_br", 147, 163, 1'b1);
        probe("ol_inner_r", 145, 150, 1'b0);
        probe("ol_right", 146, 150, 1'b1);

        // mid-frame request takes effect next frame
        req(50, 50, 1'b0);
        vb_pulse(3);
        req(200, 50, 1'b0);
        probe("mid_old", 50, 60, 1'b1);
        probe("mid_new", 200, 60, 1'b0);
        vb_pulse(3);
        probe("next_old", 50, 60, 1'b0);
        probe("next_new", 200, 60, 1'b1);

        // latest of several requests wins
        ack_cnt = 0;
        req(10, 50, 1'b0);
        idle();
        req(20, 50, 1'b0);
        req(30, 50, 1'b0);
        vb_pulse(3);
        probe("last_in", 77, 60, 1'b1);
        probe("last_out", 20, 60, 1'b0);
        check("ack_multi", 64'(ack_cnt), 64'd1);

        // request on the boundary cycle itself
        pos_valid = 1'b1; xpos = 12'd300; ypos = 12'd50; outline_en = 1'b0;
        drive(5, 600, 1'b1, 12'h0aa);
        tick();
        pos_valid = 1'b0;
        check("bnd_ack", 64'(pos_ack), 64'd1);
        vb_pulse(2);
        probe("bnd_new", 300, 60, 1'b1);
        probe("bnd_old", 30, 60, 1'b0);

        // clipping near the counter end, then reset mid-frame
        req(1000, 50, 1'b0);
        vb_pulse(3);
        for (int h = 0; h < 8; h++) probe("no_wrap", h, 60, 1'b0);
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 1055), $urandom_range(40, 130), 1'b0,
                  12'($urandom));
            tick();
        end
        rst = 1'b0;
        #2;
        check("mid_rst_bus", 64'(bus_out), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_ack", 64'(pos_ack), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        probe("post_rst", 1000, 60, 1'b0);
        vb_pulse(3);
        probe("post_rst_f", 20, 60, 1'b0);
        for (int i = 0; i < 100; i++) idle();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int hc, vc;
            bit vb;
            vb = (c % 300) < 12;
            if ($urandom_range(0, 1) == 1 && m_av) begin
                hc = m_ax + $urandom_range(0, W + 5) - 3;
                vc = m_ay + $urandom_range(0, H + 5) - 3;
                if (hc < 0) hc = 0;
                if (vc < 0) vc = 0;
                if (hc > 2047) hc = 2047;
                if (vc > 2047) vc = 2047;
            end else begin
                hc = $urandom_range(0, 1055);
                vc = $urandom_range(0, 627);
            end
            pos_valid  = ($urandom_range(0, 39) == 0);
            xpos       = 12'($urandom_range(0, 1100));
            ypos       = 12'($urandom_range(0, 700));
            outline_en = 1'($urandom);
            drive(hc, vc, vb, 12'($urandom));
            tick();
        end
        pos_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
